// File: rtl/counter_down_3_0.sv
// 2-bit down counter with enable prescaler, synchronous load, wrap/stop-at-zero
// modes, terminal-count pulse, sticky DONE flag and registered one-hot decode.
module counter_down_3_0 #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       CLK_IN,
  input  logic       CLR_FF,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [1:0] LOAD_VAL,
  input  logic       WRAP,
  output logic       D1,
  output logic       D0,
  output logic       TC,
  output logic       DONE,
  output logic       ZERO,
  output logic [3:0] Y
);

  localparam int unsigned   PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [1:0]    cnt, cnt_nxt;
  logic [PW-1:0] ps, ps_nxt;
  logic          done_nxt, tc_nxt, tick;

  always_comb begin
    cnt_nxt  = cnt;
    ps_nxt   = ps;
    done_nxt = DONE;
    tc_nxt   = 1'b0;
    tick     = EN && (ps == PS_LAST);
    if (LOAD) begin
      cnt_nxt  = LOAD_VAL;
      ps_nxt   = '0;
      done_nxt = 1'b0;
    end else if (EN) begin
      ps_nxt = tick ? '0 : ps + PW'(1);
      if (tick) begin
        if (cnt != 2'd0) begin
          cnt_nxt = cnt - 2'd1;
        end else if (WRAP) begin
          cnt_nxt  = 2'd3;
          tc_nxt   = 1'b1;
          done_nxt = 1'b0;
        end else if (!DONE) begin
          // first stop at zero only: later ticks hold with TC low
          done_nxt = 1'b1;
          tc_nxt   = 1'b1;
        end
      end
    end
  end

  // Y is decoded from cnt_nxt so it changes on the same edge as the count
  always_ff @(posedge CLK_IN or negedge CLR_FF) begin
    if (!CLR_FF) begin
      cnt  <= 2'd3;
      ps   <= '0;
      DONE <= 1'b0;
      TC   <= 1'b0;
      Y    <= 4'b1000;
    end else begin
      cnt  <= cnt_nxt;
      ps   <= ps_nxt;
      DONE <= done_nxt;
      TC   <= tc_nxt;
      Y    <= 4'b0001 << cnt_nxt;
    end
  end

  assign {D1, D0} = cnt;
  assign ZERO     = (cnt == 2'd0);

endmodule
